seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..15.
REQ-002 SHALL provide parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL provide parameter DEF_PAT, default 8'b0000_1001: pattern loaded at reset, MAX_LEN bits wide.
REQ-004 SHALL provide parameter DEF_LEN, default 4: pattern length loaded at reset.
REQ-005 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL provide port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL provide port data, input, 1 bit: serial bit stream, one bit sampled per clock.
REQ-008 SHALL provide port pat_load, input, 1 bit: synchronous pattern/length load strobe.
REQ-009 SHALL provide port pat_in, input, MAX_LEN bits: new pattern. The first bit received is compared with pat_in[len-1]; the last bit received is compared with pat_in[0].
REQ-010 SHALL provide port len_in, input, 4 bits: new pattern length.
REQ-011 SHALL provide port overlap_en, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-012 SHALL provide port clr_cnt, input, 1 bit: synchronous clear of match_cnt.
REQ-013 SHALL provide port detector, output, 1 bit: registered one-cycle match pulse.
REQ-014 SHALL provide port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-015 SHALL hold internal state: hist, a MAX_LEN-bit shift register; vcnt, the count of valid history bits, saturating at MAX_LEN; pat_r; len_r.
REQ-016 SHALL, on each clock with pat_load=0, perform hist <= {hist[MAX_LEN-2:0], data} and vcnt <= min(vcnt+1, MAX_LEN).
REQ-017 SHALL define match as: len_r != 0, post-shift vcnt >= len_r, and post-shift hist[len_r-1:0] == pat_r[len_r-1:0].
REQ-018 SHALL register detector as the match value, so detector is high for exactly the one cycle after the edge that sampled the final pattern bit (Moore, latency 1).
REQ-019 SHALL, on a match with overlap_en=0, set vcnt to 0, so the next match needs len_r fresh bits.
REQ-020 SHALL, on a match with overlap_en=1, retain hist/vcnt, so a suffix of one match may start the next.
REQ-021 SHALL sample overlap_en on every edge; a change applies from the current sampled bit, and matches already flagged are not altered.
REQ-022 SHALL, when pat_load=1: pat_r <= pat_in; len_r <= len_in, clamped to MAX_LEN if len_in > MAX_LEN; vcnt <= 0; detector <= 0; data ignored that cycle.
REQ-023 SHALL treat len_r=0 as detection disabled: detector stays 0 and history still shifts.
REQ-024 SHALL increment match_cnt by 1 on each cycle detector is set, saturating at 2^CNT_W-1 with no wrap.
REQ-025 SHALL give clr_cnt priority over a simultaneous increment: match_cnt becomes 0.
REQ-026 SHALL give pat_load priority over data. A match is not counted on a pat_load cycle.
REQ-027 SHALL keep every output a direct register output, with no combinational path from an input to an output.

Reset
REQ-028 SHALL, while rstn=0, asynchronously force: detector=0, match_cnt=0, hist=0, vcnt=0, pat_r=DEF_PAT, len_r=DEF_LEN.
REQ-029 SHALL, on reset assertion mid-pattern, discard partial history; detection restarts from empty history after rstn rises.
REQ-030 SHALL sample the first data bit on the first rising clk edge after rstn deasserts.

Verification
REQ-031 SHALL cover: default pattern 1001, overlap_en=0, stream 1001001 -> one detector pulse, cycle after bit 4; match_cnt=1.
REQ-032 SHALL cover: same stream, overlap_en=1 -> pulses after bit 4 and bit 7; match_cnt=2.
REQ-033 SHALL cover: pat_load with pat_in=8'b1011_0110, len_in=8, then stream 10110110 -> single pulse after bit 8. Also len_in=12 with MAX_LEN=8 -> len_r reads back as 8.
REQ-034 SHALL cover: CNT_W=2, overlap_en=1, pattern 11 (len 2), stream of 6 ones -> 5 pulses, match_cnt stops at 3. A clr_cnt coincident with a pulse -> match_cnt=0.
REQ-035 SHALL cover: rstn pulsed low after bits 100 of 1001 -> detector=0 and match_cnt=0 immediately. The following 1 gives no pulse; a fresh 1001 gives a pulse.
REQ-036 SHALL cover: len_in=0 loaded, random 64-bit stream -> detector never high, match_cnt stays 0.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with runtime-loadable pattern/length,
// selectable overlapping detection and a saturating match counter.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_1001,
  parameter int DEF_LEN = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               data,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [3:0]         len_in,
  input  logic               overlap_en,
  input  logic               clr_cnt,
  output logic               detector,
  output logic [CNT_W-1:0]   match_cnt
);
  localparam logic [3:0] ML = 4'(MAX_LEN);
  logic [MAX_LEN-1:0] hist, pat_r, hist_n, mask;
  logic [3:0] vcnt, len_r, vcnt_n;
  logic match;
  logic [CNT_W-1:0] cnt_n;
  always_comb begin
    hist_n = MAX_LEN'({hist, data});
    vcnt_n = (vcnt >= ML) ? ML : vcnt + 4'd1;
    mask = ~({MAX_LEN{1'b1}} << len_r);
    match = (len_r != 4'd0) && (vcnt_n >= len_r) && (((hist_n ^ pat_r) & mask) == '0);
    cnt_n = clr_cnt ? '0 : (match && !pat_load && ~&match_cnt) ? match_cnt + CNT_W'(1) : match_cnt;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      hist <= '0;
      vcnt <= 4'd0;
      pat_r <= DEF_PAT;
      len_r <= 4'(DEF_LEN);
      detector <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_cnt <= cnt_n;
      if (pat_load) begin
        pat_r <= pat_in;
        len_r <= (len_in > ML) ? ML : len_in;
        vcnt <= 4'd0;
        detector <= 1'b0;
      end else begin
        hist <= hist_n;
        // non-overlapping mode restarts the history count after each hit
        vcnt <= (match && !overlap_en) ? 4'd0 : vcnt_n;
        detector <= match;
      end
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench for seq_detect_param (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_param;
  logic clk = 0, rstn = 0, data = 0, pat_load = 0, overlap_en = 0, clr_cnt = 0;
  logic [7:0] pat_in = '0;
  logic [3:0] len_in = '0;
  logic detector;
  logic [1:0] match_cnt;
  int total = 0, bad = 0, pulses = 0;
  int q_det[$], q_cnt[$];
  logic [7:0] m_hist, m_pat;
  int m_len, m_valid, m_cnt;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(2), .DEF_PAT(8'b0000_1001), .DEF_LEN(4)) dut (
    .clk(clk), .rstn(rstn), .data(data), .pat_load(pat_load), .pat_in(pat_in),
    .len_in(len_in), .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .detector(detector), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = '0; m_pat = 8'b0000_1001; m_len = 4; m_valid = 0; m_cnt = 0;
    q_det.delete(); q_cnt.delete();
  endtask

  task automatic step(input logic d, input logic ld = 0, input logic [7:0] pin = 0,
                      input int lin = 0, input logic clr = 0);
    int e_det;
    data = d; pat_load = ld; pat_in = pin; len_in = 4'(lin); clr_cnt = clr;
    e_det = 0;
    if (ld) begin
      m_pat = pin; m_len = (lin > 8) ? 8 : lin; m_valid = 0;
    end else begin
      m_hist = {m_hist[6:0], d};
      m_valid = (m_valid < 8) ? m_valid + 1 : 8;
      e_det = (m_len != 0 && m_valid >= m_len) ? 1 : 0;
      for (int i = 0; i < m_len; i++) if (m_hist[i] !== m_pat[i]) e_det = 0;
      if (e_det != 0 && !overlap_en) m_valid = 0;
    end
    if (clr) m_cnt = 0;
    else if (e_det != 0 && m_cnt < 3) m_cnt++;
    q_det.push_back(e_det);
    q_cnt.push_back(m_cnt);
    @(posedge clk);
    #1;
    chk("detector", int'(detector), q_det.pop_front());
    chk("match_cnt", int'(match_cnt), q_cnt.pop_front());
    if (detector) pulses++;
    pat_load = 0; clr_cnt = 0;
  endtask

  task automatic stream(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i] == 8'h31);
  endtask

  task automatic do_reset();
    rstn = 0;
    model_reset();
    #1;
    chk("rst_detector", int'(detector), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    @(posedge clk);
    #1;
    rstn = 1;
    pulses = 0;
  endtask

  initial begin
    do_reset();
    overlap_en = 0;
    stream("1001001");
    chk("nonovl_pulses", pulses, 1);
    chk("nonovl_cnt", int'(match_cnt), 1);

    do_reset();
    overlap_en = 1;
    stream("1001001");
    chk("ovl_pulses", pulses, 2);
    chk("ovl_cnt", int'(match_cnt), 2);

    do_reset();
    overlap_en = 0;
    step(0, 1, 8'b1011_0110, 8);
    stream("10110110");
    chk("len8_pulses", pulses, 1);
    step(0, 1, 8'b1011_0110, 12);
    chk("len_clamp", int'(dut.len_r), 8);
    stream("10110110");
    chk("clamp_pulses", pulses, 2);

    do_reset();
    overlap_en = 1;
    step(0, 1, 8'b0000_0011, 2);
    stream("111111");
    chk("sat_pulses", pulses, 5);
    chk("sat_cnt", int'(match_cnt), 3);
    step(1, 0, 0, 0, 1);
    chk("clr_on_pulse_det", int'(detector), 1);
    chk("clr_on_pulse_cnt", int'(match_cnt), 0);

    do_reset();
    overlap_en = 0;
    stream("100");
    do_reset();
    step(1);
    chk("post_rst_no_pulse", int'(detector), 0);
    stream("1001");
    chk("post_rst_pulses", pulses, 1);

    do_reset();
    step(0, 1, 8'hff, 0);
    for (int i = 0; i < 64; i++) step(1'($urandom_range(0, 1)));
    chk("len0_pulses", pulses, 0);
    chk("len0_cnt", int'(match_cnt), 0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      overlap_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0)
        step(1'($urandom_range(0, 1)), 1, 8'($urandom), $urandom_range(0, 15));
      else
        step(1'($urandom_range(0, 1)), 0, 0, 0, $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
